// File: rtl/mul_arb_ctrl_if.sv
// Bundle of the two requester ports and the result port of mul_arb_ctrl.
//   req0_valid/req0_a/req0_b/req0_ready : requester 0 operand handshake
//   req1_valid/req1_a/req1_b/req1_ready : requester 1 operand handshake
//   res_valid/res_ready/res_data/res_id : product return, tagged with requester ID
//   busy                                : multiplier occupied (RUN or DONE)
// The master modport is the requester/consumer side, the slave modport the multiplier.
interface mul_arb_ctrl_if #(
  parameter int W = 4
);
  logic             req0_valid;
  logic [W-1:0]     req0_a;
  logic [W-1:0]     req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [W-1:0]     req1_a;
  logic [W-1:0]     req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [2*W-1:0]   res_data;
  logic             res_id;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  res_valid, res_data, res_id, busy,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output res_valid, res_data, res_id, busy,
    input  res_ready
  );
endinterface

// File: rtl/mul_arb_ctrl.sv
// Sequential shift-add multiplier shared round-robin between two requesters.
// One 2W-bit adder accumulates one partial product per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mul_arb_ctrl_if slave modport (two operand ports, result port, busy)
// Parameters: W operand width, EARLY_EXIT stops once remaining multiplier bits are zero.
module mul_arb_ctrl #(
  parameter int W          = 4,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  mul_arb_ctrl_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic             rr_r, rr_nx_s;
  logic [2*W-1:0]   mcand_r, mcand_nx_s;
  logic [W-1:0]     mplr_r, mplr_nx_s;
  logic [2*W-1:0]   acc_r, acc_nx_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s;
  logic             id_r, id_nx_s;
  logic             res_valid_r, res_valid_nx_s;
  logic [2*W-1:0]   res_data_r, res_data_nx_s;
  logic             res_id_r, res_id_nx_s;
  logic             busy_r, busy_nx_s;

  logic             grant0_s, grant1_s;
  logic [W-1:0]     op_a_s, op_b_s;
  logic [2*W-1:0]   sum_s, mcand_sh_s;
  logic [W-1:0]     mplr_sh_s;
  logic [CW-1:0]    cnt_inc_s;

  // A lone valid requester always wins; on contention rr_r picks (0 -> req0, 1 -> req1).
  // Ready is suppressed during reset so nothing is accepted while rst is high.
  assign grant0_s = (state_r == IDLE) & ~rst & bus.req0_valid & ~(bus.req1_valid & rr_r);
  assign grant1_s = (state_r == IDLE) & ~rst & bus.req1_valid & ~(bus.req0_valid & ~rr_r);
  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;

  // The single shared adder: add the shifted multiplicand when the current multiplier bit is set.
  assign sum_s      = acc_r + (mplr_r[0] ? mcand_r : {(2*W){1'b0}});
  assign mcand_sh_s = {mcand_r[2*W-2:0], 1'b0};
  assign mplr_sh_s  = {1'b0, mplr_r[W-1:1]};
  assign cnt_inc_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};

  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_id    = res_id_r;
  assign bus.busy      = busy_r;

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_nx_s = state_r;
    rr_nx_s    = rr_r;
    mcand_nx_s = mcand_r;
    mplr_nx_s  = mplr_r;
    acc_nx_s   = acc_r;
    cnt_nx_s   = cnt_r;
    id_nx_s    = id_r;
    op_a_s     = grant1_s ? bus.req1_a : bus.req0_a;
    op_b_s     = grant1_s ? bus.req1_b : bus.req0_b;

    case (state_r)
      IDLE: begin
        if (grant0_s | grant1_s) begin
          mcand_nx_s = {{W{1'b0}}, op_a_s};
          mplr_nx_s  = op_b_s;
          acc_nx_s   = {(2*W){1'b0}};
          cnt_nx_s   = {CW{1'b0}};
          id_nx_s    = grant1_s;
          rr_nx_s    = ~rr_r;
          if (EARLY_EXIT && (op_b_s == {W{1'b0}})) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        acc_nx_s   = sum_s;
        mcand_nx_s = mcand_sh_s;
        mplr_nx_s  = mplr_sh_s;
        cnt_nx_s   = cnt_inc_s;
        if ((cnt_inc_s == CW'(W)) || (EARLY_EXIT && (mplr_sh_s == {W{1'b0}}))) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (res_valid_r & bus.res_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they appear with the DONE state itself.
    res_valid_nx_s = (state_nx_s == DONE);
    busy_nx_s      = (state_nx_s != IDLE);
    res_data_nx_s  = (state_nx_s == DONE) ? acc_nx_s : {(2*W){1'b0}};
    res_id_nx_s    = (state_nx_s == DONE) ? id_nx_s : 1'b0;
  end

  // State, datapath and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_r        <= 1'b0;
      mcand_r     <= {(2*W){1'b0}};
      mplr_r      <= {W{1'b0}};
      acc_r       <= {(2*W){1'b0}};
      cnt_r       <= {CW{1'b0}};
      id_r        <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {(2*W){1'b0}};
      res_id_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      rr_r        <= rr_nx_s;
      mcand_r     <= mcand_nx_s;
      mplr_r      <= mplr_nx_s;
      acc_r       <= acc_nx_s;
      cnt_r       <= cnt_nx_s;
      id_r        <= id_nx_s;
      res_valid_r <= res_valid_nx_s;
      res_data_r  <= res_data_nx_s;
      res_id_r    <= res_id_nx_s;
      busy_r      <= busy_nx_s;
    end
  end
endmodule

// File: tb/tb_mul_arb_ctrl.sv
// Directed bench for mul_arb_ctrl: dut0 has EARLY_EXIT=0, dut1 has EARLY_EXIT=1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mul_arb_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_arb_ctrl_if #(.W(4)) bus0 ();
  mul_arb_ctrl_if #(.W(4)) bus1 ();

  mul_arb_ctrl #(.W(4), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  mul_arb_ctrl #(.W(4), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic       v0[2], v1[2], rrdy[2];
  logic [3:0] a0[2], b0[2], a1[2], b1[2];
  logic       rdy0[2], rdy1[2], rvld[2], rid[2], bsy[2];
  logic [7:0] rdat[2];

  assign bus0.req0_valid = v0[0];  assign bus1.req0_valid = v0[1];
  assign bus0.req0_a     = a0[0];  assign bus1.req0_a     = a0[1];
  assign bus0.req0_b     = b0[0];  assign bus1.req0_b     = b0[1];
  assign bus0.req1_valid = v1[0];  assign bus1.req1_valid = v1[1];
  assign bus0.req1_a     = a1[0];  assign bus1.req1_a     = a1[1];
  assign bus0.req1_b     = b1[0];  assign bus1.req1_b     = b1[1];
  assign bus0.res_ready  = rrdy[0]; assign bus1.res_ready = rrdy[1];
  assign rdy0[0] = bus0.req0_ready; assign rdy0[1] = bus1.req0_ready;
  assign rdy1[0] = bus0.req1_ready; assign rdy1[1] = bus1.req1_ready;
  assign rvld[0] = bus0.res_valid;  assign rvld[1] = bus1.res_valid;
  assign rdat[0] = bus0.res_data;   assign rdat[1] = bus1.res_data;
  assign rid[0]  = bus0.res_id;     assign rid[1]  = bus1.res_id;
  assign bsy[0]  = bus0.busy;       assign bsy[1]  = bus1.busy;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int e = 0; e < 2; e++) begin
      v0[e] = 1'b0; a0[e] = 4'd0; b0[e] = 4'd0;
      v1[e] = 1'b0; a1[e] = 4'd0; b1[e] = 4'd0;
      rrdy[e] = 1'b1;
    end
  endtask

  // Starts in the cycle after the accept (cycle 1); returns in the first cycle after the handshake.
  task automatic wait_res(input int e, input bit stall, output int lat,
                          output logic [7:0] d, output logic id);
    bit done;
    lat = -1; d = 8'd0; id = 1'b0; done = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      rrdy[e] = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (rvld[e] === 1'b1) begin
        if (lat < 0) begin
          lat = c; d = rdat[e]; id = rid[e];
        end
        done = rrdy[e];
      end
      tick();
    end
    rrdy[e] = 1'b1;
  endtask

  task automatic run_op(input int e, input bit port, input logic [3:0] a, input logic [3:0] b,
                        input bit stall, output int lat, output logic [7:0] d, output logic id);
    bit got;
    got = 1'b0; lat = -1; d = 8'd0; id = 1'b0;
    if (port) begin v1[e] = 1'b1; a1[e] = a; b1[e] = b; end
    else      begin v0[e] = 1'b1; a0[e] = a; b0[e] = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? (rdy1[e] === 1'b1) : (rdy0[e] === 1'b1);
      tick();
    end
    v0[e] = 1'b0; v1[e] = 1'b0;
    if (got) wait_res(e, stall, lat, d, id);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    for (int e = 0; e < 2; e++) begin v0[e] = 1'b1; v1[e] = 1'b1; end
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      n_tests++; if (rvld[e] !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid dut%0d: got %b want 0", e, rvld[e]); end
      n_tests++; if (rdat[e] !== 8'd0) begin n_fail++; $display("FAIL reset_res_data dut%0d: got %h want 00", e, rdat[e]); end
      n_tests++; if (rid[e] !== 1'b0) begin n_fail++; $display("FAIL reset_res_id dut%0d: got %b want 0", e, rid[e]); end
      n_tests++; if (bsy[e] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", e, bsy[e]); end
      n_tests++; if (rdy0[e] !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready dut%0d: got %b want 0", e, rdy0[e]); end
      n_tests++; if (rdy1[e] !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready dut%0d: got %b want 0", e, rdy1[e]); end
    end
    clear_in();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_contention();
    int lat; logic [7:0] d; logic id;
    v0[0] = 1'b1; a0[0] = 4'd3; b0[0] = 4'd5;
    v1[0] = 1'b1; a1[0] = 4'd7; b1[0] = 4'd6;
    @(negedge clk);
    n_tests++; if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) begin n_fail++; $display("FAIL cont_first_grant: got rdy0=%b rdy1=%b want 1 0", rdy0[0], rdy1[0]); end
    tick();
    v0[0] = 1'b0;
    wait_res(0, 1'b0, lat, d, id);
    n_tests++; if (d !== 8'd15 || id !== 1'b0 || lat !== 5) begin n_fail++; $display("FAIL cont_res0: got d=%0d id=%b lat=%0d want 15 0 5", d, id, lat); end
    v0[0] = 1'b1; a0[0] = 4'd4; b0[0] = 4'd4;
    @(negedge clk);
    n_tests++; if (rdy1[0] !== 1'b1 || rdy0[0] !== 1'b0) begin n_fail++; $display("FAIL cont_second_grant: got rdy0=%b rdy1=%b want 0 1", rdy0[0], rdy1[0]); end
    tick();
    v1[0] = 1'b0;
    wait_res(0, 1'b0, lat, d, id);
    n_tests++; if (d !== 8'd42 || id !== 1'b1) begin n_fail++; $display("FAIL cont_res1: got d=%0d id=%b want 42 1", d, id); end
    @(negedge clk);
    n_tests++; if (rdy0[0] !== 1'b1) begin n_fail++; $display("FAIL cont_loser_grant: got rdy0=%b want 1", rdy0[0]); end
    tick();
    v0[0] = 1'b0;
    wait_res(0, 1'b0, lat, d, id);
    n_tests++; if (d !== 8'd16 || id !== 1'b0) begin n_fail++; $display("FAIL cont_res2: got d=%0d id=%b want 16 0", d, id); end
  endtask

  task automatic test_single();
    v0[0] = 1'b1; a0[0] = 4'd15; b0[0] = 4'd15;
    @(negedge clk);
    n_tests++; if (rdy0[0] !== 1'b1) begin n_fail++; $display("FAIL single_grant: got %b want 1", rdy0[0]); end
    tick();
    v0[0] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_tests++; if (bsy[0] !== (c <= 5)) begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", c, bsy[0], (c <= 5)); end
      n_tests++; if (rvld[0] !== (c == 5)) begin n_fail++; $display("FAIL single_valid c%0d: got %b want %b", c, rvld[0], (c == 5)); end
      if (c == 5) begin
        n_tests++; if (rdat[0] !== 8'hE1 || rid[0] !== 1'b0) begin n_fail++; $display("FAIL single_res: got %h id %b want e1 0", rdat[0], rid[0]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    v1[0] = 1'b1; a1[0] = 4'd5; b1[0] = 4'd3;
    @(negedge clk);
    n_tests++; if (rdy1[0] !== 1'b1) begin n_fail++; $display("FAIL bp_grant: got %b want 1", rdy1[0]); end
    tick();
    v1[0] = 1'b0; rrdy[0] = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (rvld[0] === 1'b1);
      if (!seen) tick();
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL bp_timeout: got no res_valid want res_valid within 20 cycles"); end
    tick();
    v0[0] = 1'b1; a0[0] = 4'd1; b0[0] = 4'd1;
    v1[0] = 1'b1; a1[0] = 4'd2; b1[0] = 4'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (rvld[0] !== 1'b1 || rdat[0] !== 8'd15 || rid[0] !== 1'b1 || rdy0[0] !== 1'b0 || rdy1[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: got v=%b d=%0d id=%b r0=%b r1=%b want 1 15 1 0 0", c, rvld[0], rdat[0], rid[0], rdy0[0], rdy1[0]);
      end
      tick();
    end
    v0[0] = 1'b0; v1[0] = 1'b0; rrdy[0] = 1'b1;
    @(negedge clk);
    n_tests++; if (rvld[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b want 1", rvld[0]); end
    tick();
    @(negedge clk);
    n_tests++; if (rvld[0] !== 1'b0 || bsy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got v=%b busy=%b want 0 0", rvld[0], bsy[0]); end
    tick();
  endtask

  task automatic test_early_exit();
    logic [3:0] ta[3];
    logic [3:0] tb_b[3];
    int ee_lat[3];
    int lat, exp_lat; logic [7:0] d; logic id;
    ta[0] = 4'd5; tb_b[0] = 4'd0; ee_lat[0] = 1;
    ta[1] = 4'd9; tb_b[1] = 4'd1; ee_lat[1] = 2;
    ta[2] = 4'd3; tb_b[2] = 4'd8; ee_lat[2] = 5;
    for (int e = 0; e < 2; e++) begin
      for (int i = 0; i < 3; i++) begin
        exp_lat = (e == 1) ? ee_lat[i] : 5;
        run_op(e, 1'b0, ta[i], tb_b[i], 1'b0, lat, d, id);
        n_tests++;
        if (d !== 8'(ta[i] * tb_b[i]) || id !== 1'b0 || lat !== exp_lat) begin
          n_fail++;
          $display("FAIL early_exit dut%0d a=%0d b=%0d: got d=%0d id=%b lat=%0d want %0d 0 %0d",
                   e, ta[i], tb_b[i], d, id, lat, ta[i] * tb_b[i], exp_lat);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [7:0] d; logic id;
    v0[0] = 1'b1; a0[0] = 4'd6; b0[0] = 4'd7;
    @(negedge clk);
    n_tests++; if (rdy0[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_grant: got %b want 1", rdy0[0]); end
    tick();
    v0[0] = 1'b0;
    tick();
    n_tests++; if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b want 1", bsy[0]); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bsy[0] !== 1'b0 || rvld[0] !== 1'b0 || rdat[0] !== 8'd0 || rid[0] !== 1'b0 || rdy0[0] !== 1'b0 || rdy1[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async_clear: got busy=%b v=%b d=%0d id=%b want all 0", bsy[0], rvld[0], rdat[0], rid[0]);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++; if (rvld[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_no_result c%0d: got %b want 0", c, rvld[0]); end
      tick();
    end
    v0[0] = 1'b1; a0[0] = 4'd4; b0[0] = 4'd5;
    v1[0] = 1'b1; a1[0] = 4'd2; b1[0] = 4'd3;
    @(negedge clk);
    n_tests++; if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_rr_restart: got rdy0=%b rdy1=%b want 1 0", rdy0[0], rdy1[0]); end
    tick();
    v0[0] = 1'b0;
    wait_res(0, 1'b0, lat, d, id);
    n_tests++; if (d !== 8'd20 || id !== 1'b0) begin n_fail++; $display("FAIL rmid_res0: got d=%0d id=%b want 20 0", d, id); end
    @(negedge clk);
    n_tests++; if (rdy1[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_req1_grant: got %b want 1", rdy1[0]); end
    tick();
    v1[0] = 1'b0;
    wait_res(0, 1'b0, lat, d, id);
    n_tests++; if (d !== 8'd6 || id !== 1'b1) begin n_fail++; $display("FAIL rmid_res1: got d=%0d id=%b want 6 1", d, id); end
  endtask

  task automatic test_exhaustive();
    int lat, exp_lat, k; logic [7:0] d; logic id;
    logic [3:0] ba;
    for (int e = 0; e < 2; e++) begin
      for (int p = 0; p < 2; p++) begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            ba = 4'(b);
            k = 0;
            for (int j = 0; j < 4; j++) if (ba[j]) k = j + 1;
            exp_lat = (e == 1) ? (k + 1) : 5;
            run_op(e, p[0], 4'(a), ba, 1'b1, lat, d, id);
            n_tests++;
            if (d !== 8'(a * b) || id !== p[0] || lat !== exp_lat) begin
              n_fail++;
              $display("FAIL exhaustive dut%0d port%0d a=%0d b=%0d: got d=%0d id=%b lat=%0d want %0d %0d %0d",
                       e, p, a, b, d, id, lat, a * b, p, exp_lat);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_early_exit();
    test_reset_mid_op();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running want completion before 900000");
    $fatal(1);
  end
endmodule
